// File: rtl/mioc_pkg.sv
// Shared constants for the MIOC DRAM timing controller: FSM encoding and
// default timing parameters.
package mioc_pkg;

    localparam int DEF_REF_BITS      = 8;
    localparam int DEF_PRECHARGE_CYC = 1;
    localparam int DEF_CAS_DLY       = 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ROW  = 3'd1;
    localparam logic [2:0] ST_COL  = 3'd2;
    localparam logic [2:0] ST_CAS  = 3'd3;
    localparam logic [2:0] ST_REF  = 3'd4;
    localparam logic [2:0] ST_PRE  = 3'd5;

    // States in which the row strobe is held low.
    function automatic logic ras_active(input logic [2:0] st);
        return (st == ST_ROW) || (st == ST_COL) || (st == ST_CAS) || (st == ST_REF);
    endfunction

    // States in which the DRAM address mux presents the column address.
    function automatic logic col_phase(input logic [2:0] st);
        return (st == ST_COL) || (st == ST_CAS);
    endfunction

endpackage

// File: rtl/mioc_refresh_cnt.sv
// Refresh row counter: wraps through every DRAM row, one step per
// completed refresh cycle.
module mioc_refresh_cnt #(
    parameter int REF_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc_en,
    output logic [REF_BITS-1:0] count,
    output logic                msb
);

    logic [REF_BITS-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (inc_en) begin
            count_reg <= count_reg + REF_BITS'(1);
        end
    end

    assign count = count_reg;
    assign msb   = count_reg[REF_BITS-1];

endmodule

// File: rtl/mioc_dram_ctrl.sv
// DRAM RAS/CAS/MUX timing generator driven by the buffered Z80 bus, with
// RAS-only refresh extended to the full row range by an internal counter.
module mioc_dram_ctrl
    import mioc_pkg::*;
#(
    parameter int REF_BITS      = DEF_REF_BITS,
    parameter int PRECHARGE_CYC = DEF_PRECHARGE_CYC,
    parameter int CAS_DLY       = DEF_CAS_DLY
) (
    input  logic                B_PHI,
    input  logic                RST_N,
    input  logic                BMREQ_N,
    input  logic                BRD_N,
    input  logic                N_BWR,
    input  logic                BRFSH_N,
    input  logic                BM1_N,
    input  logic                DMA_N,
    input  logic                BA7,
    input  logic                BA15,
    input  logic                RAM_SEL,
    input  logic                EXP_SEL,
    output logic                RAS_N,
    output logic                CAS1_N,
    output logic                CAS2_N,
    output logic                MUX,
    output logic                RA7,
    output logic [REF_BITS-1:0] REFCNT
);

    localparam logic [1:0] PRE_LAST = 2'(PRECHARGE_CYC);
    localparam logic [1:0] CAS_LAST = 2'(CAS_DLY);

    logic [2:0] state_reg, state_next;
    logic [1:0] pre_cnt_reg, pre_cnt_next;
    logic [1:0] dly_cnt_reg, dly_cnt_next;
    logic       exp_reg, exp_next;
    logic       ras_n_reg, mux_reg;
    logic       ra7_reg, ra7_next;
    logic [1:0] cas_n;
    logic       ref_inc;
    logic       ref_msb;
    logic       access_req;
    logic       refresh_req;

    // Refresh takes priority over any data strobe; M1 counts as a read.
    assign refresh_req = !BMREQ_N && !BRFSH_N;
    assign access_req  = !BMREQ_N && BRFSH_N && RAM_SEL &&
                         (!BRD_N || !N_BWR || !DMA_N || !BM1_N);

    assign ref_inc = (state_reg == ST_REF) && BMREQ_N;

    mioc_refresh_cnt #(
        .REF_BITS (REF_BITS)
    ) u_refresh_cnt (
        .clk    (B_PHI),
        .rst_n  (RST_N),
        .inc_en (ref_inc),
        .count  (REFCNT),
        .msb    (ref_msb)
    );

    always_comb begin
        state_next   = state_reg;
        pre_cnt_next = pre_cnt_reg;
        dly_cnt_next = dly_cnt_reg;
        exp_next     = exp_reg;
        ra7_next     = ra7_reg;
        case (state_reg)
            ST_IDLE: begin
                if (refresh_req) begin
                    state_next = ST_REF;
                    ra7_next   = ref_msb;
                end else if (access_req) begin
                    state_next = ST_ROW;
                    exp_next   = EXP_SEL;
                    ra7_next   = BA7;
                end
            end
            ST_ROW: begin
                if (BMREQ_N) begin
                    state_next   = ST_PRE;
                    pre_cnt_next = 2'd1;
                end else begin
                    state_next   = ST_COL;
                    dly_cnt_next = 2'd1;
                    ra7_next     = BA15;
                end
            end
            ST_COL: begin
                if (BMREQ_N) begin
                    state_next   = ST_PRE;
                    pre_cnt_next = 2'd1;
                end else if (dly_cnt_reg == CAS_LAST) begin
                    state_next = ST_CAS;
                end else begin
                    dly_cnt_next = dly_cnt_reg + 2'd1;
                    ra7_next     = BA15;
                end
            end
            ST_CAS, ST_REF: begin
                if (BMREQ_N) begin
                    state_next   = ST_PRE;
                    pre_cnt_next = 2'd1;
                end
            end
            ST_PRE: begin
                // A request seen on the exit edge is picked up from IDLE next.
                if (pre_cnt_reg == PRE_LAST) begin
                    state_next   = ST_IDLE;
                    pre_cnt_next = 2'd0;
                end else begin
                    pre_cnt_next = pre_cnt_reg + 2'd1;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                pre_cnt_next = 2'd0;
            end
        endcase
    end

    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            state_reg   <= ST_IDLE;
            pre_cnt_reg <= 2'd0;
            dly_cnt_reg <= 2'd0;
            exp_reg     <= 1'b0;
            ras_n_reg   <= 1'b1;
            mux_reg     <= 1'b0;
            ra7_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pre_cnt_reg <= pre_cnt_next;
            dly_cnt_reg <= dly_cnt_next;
            exp_reg     <= exp_next;
            ras_n_reg   <= !ras_active(state_next);
            mux_reg     <= col_phase(state_next);
            ra7_reg     <= ra7_next;
        end
    end

    // One column strobe per bank; the bank latched at row entry picks which.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cas
            logic cas_n_reg;

            always_ff @(posedge B_PHI or negedge RST_N) begin
                if (!RST_N) begin
                    cas_n_reg <= 1'b1;
                end else begin
                    cas_n_reg <= !((state_next == ST_CAS) && (exp_next == 1'(gi)));
                end
            end

            assign cas_n[gi] = cas_n_reg;
        end
    endgenerate

    assign RAS_N  = ras_n_reg;
    assign MUX    = mux_reg;
    assign RA7    = ra7_reg;
    assign CAS1_N = cas_n[0];
    assign CAS2_N = cas_n[1];

endmodule

// File: tb/tb_mioc_dram_ctrl.sv
// Directed bench for the DRAM timing controller: cycle table plus refresh
// sweep and asynchronous reset sequences.
module tb_mioc_dram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bmreq_n, brd_n, n_bwr, brfsh_n, bm1_n, dma_n;
    logic       ba7, ba15, ram_sel, exp_sel;
    logic       ras_n, cas1_n, cas2_n, mux, ra7;
    logic [7:0] refcnt;

    int checks = 0;
    int errors = 0;

    mioc_dram_ctrl dut (
        .B_PHI   (clk),
        .RST_N   (rst_n),
        .BMREQ_N (bmreq_n),
        .BRD_N   (brd_n),
        .N_BWR   (n_bwr),
        .BRFSH_N (brfsh_n),
        .BM1_N   (bm1_n),
        .DMA_N   (dma_n),
        .BA7     (ba7),
        .BA15    (ba15),
        .RAM_SEL (ram_sel),
        .EXP_SEL (exp_sel),
        .RAS_N   (ras_n),
        .CAS1_N  (cas1_n),
        .CAS2_N  (cas2_n),
        .MUX     (mux),
        .RA7     (ra7),
        .REFCNT  (refcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       bmreq_n, brd_n, n_bwr, brfsh_n, dma_n, ram_sel, exp_sel, ba7, ba15;
        logic       e_ras_n, e_cas1_n, e_cas2_n, e_mux, e_ra7;
        logic [7:0] e_ref;
    } vec_t;

    localparam int NVEC = 29;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic mq, rd, wr, rf, dm, rs, ex, a7, a15,
                                input logic ras, c1, c2, mx, r7, input logic [7:0] rc);
        vec_t v;
        v.bmreq_n = mq; v.brd_n = rd; v.n_bwr = wr; v.brfsh_n = rf; v.dma_n = dm;
        v.ram_sel = rs; v.exp_sel = ex; v.ba7 = a7; v.ba15 = a15;
        v.e_ras_n = ras; v.e_cas1_n = c1; v.e_cas2_n = c2; v.e_mux = mx; v.e_ra7 = r7;
        v.e_ref = rc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bmreq_n = 1'b1; brd_n = 1'b1; n_bwr = 1'b1; brfsh_n = 1'b1; bm1_n = 1'b1;
        dma_n = 1'b1; ram_sel = 1'b1; exp_sel = 1'b0; ba7 = 1'b0; ba15 = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic e_ras, e_c1, e_c2, e_mx, e_r7,
                           input logic [7:0] e_rc);
        chk({tag, "_ras"}, 32'(ras_n), 32'(e_ras));
        chk({tag, "_cas1"}, 32'(cas1_n), 32'(e_c1));
        chk({tag, "_cas2"}, 32'(cas2_n), 32'(e_c2));
        chk({tag, "_mux"}, 32'(mux), 32'(e_mx));
        chk({tag, "_ra7"}, 32'(ra7), 32'(e_r7));
        chk({tag, "_ref"}, 32'(refcnt), 32'(e_rc));
    endtask

    // Strobe invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("inv_cas_both", 32'(!cas1_n && !cas2_n), 32'd0);
            chk("inv_cas_no_ras", 32'(ras_n && (!cas1_n || !cas2_n)), 32'd0);
        end
    end

    initial begin
        //             mq rd wr rf dm rs ex a7 a15  ras c1 c2 mx r7 ref
        vecs[0]  = mk(0, 0, 1, 1, 1, 1, 0, 1, 0,   0, 1, 1, 0, 1, 8'd0); // read ROW
        vecs[1]  = mk(0, 0, 1, 1, 1, 1, 0, 1, 0,   0, 1, 1, 1, 0, 8'd0); // COL
        vecs[2]  = mk(0, 0, 1, 1, 1, 1, 0, 1, 0,   0, 0, 1, 1, 0, 8'd0); // CAS bank1
        vecs[3]  = mk(0, 0, 1, 1, 1, 1, 0, 1, 0,   0, 0, 1, 1, 0, 8'd0); // CAS held
        vecs[4]  = mk(1, 1, 1, 1, 1, 1, 0, 1, 0,   1, 1, 1, 0, 0, 8'd0); // PRE
        vecs[5]  = mk(1, 1, 1, 1, 1, 1, 0, 0, 0,   1, 1, 1, 0, 0, 8'd0); // IDLE
        vecs[6]  = mk(0, 1, 0, 1, 1, 1, 1, 0, 1,   0, 1, 1, 0, 0, 8'd0); // write exp ROW
        vecs[7]  = mk(0, 1, 0, 1, 1, 1, 1, 0, 1,   0, 1, 1, 1, 1, 8'd0); // COL
        vecs[8]  = mk(0, 1, 0, 1, 1, 1, 1, 0, 1,   0, 1, 0, 1, 1, 8'd0); // CAS bank2
        vecs[9]  = mk(1, 1, 1, 1, 1, 1, 0, 0, 0,   1, 1, 1, 0, 1, 8'd0); // PRE
        vecs[10] = mk(0, 0, 1, 1, 1, 1, 0, 0, 0,   1, 1, 1, 0, 1, 8'd0); // pending, PRE->IDLE
        vecs[11] = mk(0, 0, 1, 1, 1, 1, 0, 0, 0,   0, 1, 1, 0, 0, 8'd0); // accepted ROW
        vecs[12] = mk(1, 1, 1, 1, 1, 1, 0, 0, 0,   1, 1, 1, 0, 0, 8'd0); // abort in ROW
        vecs[13] = mk(1, 1, 1, 1, 1, 1, 0, 0, 0,   1, 1, 1, 0, 0, 8'd0); // IDLE
        vecs[14] = mk(0, 0, 1, 1, 1, 1, 0, 1, 1,   0, 1, 1, 0, 1, 8'd0); // ROW
        vecs[15] = mk(0, 0, 1, 1, 1, 1, 0, 1, 1,   0, 1, 1, 1, 1, 8'd0); // COL
        vecs[16] = mk(1, 1, 1, 1, 1, 1, 0, 0, 0,   1, 1, 1, 0, 1, 8'd0); // abort in COL
        vecs[17] = mk(1, 1, 1, 1, 1, 1, 0, 0, 0,   1, 1, 1, 0, 1, 8'd0); // IDLE
        vecs[18] = mk(0, 0, 1, 1, 1, 0, 0, 0, 0,   1, 1, 1, 0, 1, 8'd0); // RAM_SEL=0
        vecs[19] = mk(0, 0, 1, 1, 1, 0, 0, 0, 0,   1, 1, 1, 0, 1, 8'd0); // still IDLE
        vecs[20] = mk(1, 1, 1, 1, 1, 1, 0, 0, 0,   1, 1, 1, 0, 1, 8'd0); // IDLE
        vecs[21] = mk(0, 0, 1, 0, 1, 1, 0, 1, 1,   0, 1, 1, 0, 0, 8'd0); // refresh wins
        vecs[22] = mk(1, 1, 1, 1, 1, 1, 0, 1, 1,   1, 1, 1, 0, 0, 8'd1); // PRE, REFCNT+1
        vecs[23] = mk(1, 1, 1, 1, 1, 1, 0, 1, 1,   1, 1, 1, 0, 0, 8'd1); // IDLE
        vecs[24] = mk(0, 1, 1, 1, 0, 1, 0, 1, 0,   0, 1, 1, 0, 1, 8'd1); // DMA ROW
        vecs[25] = mk(0, 1, 1, 1, 0, 1, 0, 1, 0,   0, 1, 1, 1, 0, 8'd1); // COL
        vecs[26] = mk(0, 1, 1, 1, 0, 1, 0, 1, 0,   0, 0, 1, 1, 0, 8'd1); // CAS
        vecs[27] = mk(1, 1, 1, 1, 1, 1, 0, 0, 0,   1, 1, 1, 0, 0, 8'd1); // PRE
        vecs[28] = mk(1, 1, 1, 1, 1, 1, 0, 0, 0,   1, 1, 1, 0, 0, 8'd1); // IDLE

        // Reset held for three clocks.
        idle_bus();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk_all("reset", 1, 1, 1, 0, 0, 8'd0);
        $display("reset: ras=%0b cas1=%0b cas2=%0b mux=%0b ra7=%0b ref=%0d",
                 ras_n, cas1_n, cas2_n, mux, ra7, refcnt);

        for (int i = 0; i < NVEC; i++) begin
            bmreq_n = vecs[i].bmreq_n; brd_n = vecs[i].brd_n; n_bwr = vecs[i].n_bwr;
            brfsh_n = vecs[i].brfsh_n; dma_n = vecs[i].dma_n; ram_sel = vecs[i].ram_sel;
            exp_sel = vecs[i].exp_sel; ba7 = vecs[i].ba7; ba15 = vecs[i].ba15;
            tick();
            chk_all($sformatf("v%0d", i), vecs[i].e_ras_n, vecs[i].e_cas1_n,
                    vecs[i].e_cas2_n, vecs[i].e_mux, vecs[i].e_ra7, vecs[i].e_ref);
            $display("vec %0d: ras=%0b cas1=%0b cas2=%0b mux=%0b ra7=%0b ref=%0d",
                     i, ras_n, cas1_n, cas2_n, mux, ra7, refcnt);
        end

        // Clear the counter, then sweep every refresh row.
        rst_n = 1'b0;
        #2;
        chk("rst_clear_ref", 32'(refcnt), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bmreq_n = 1'b0; brfsh_n = 1'b0; bm1_n = 1'b0;
            tick();
            chk($sformatf("sw%0d_ras", i), 32'(ras_n), 32'd0);
            chk($sformatf("sw%0d_cas", i), 32'({cas1_n, cas2_n}), 32'h3);
            chk($sformatf("sw%0d_ra7", i), 32'(ra7), 32'(i >= 128));
            chk($sformatf("sw%0d_ref", i), 32'(refcnt), 32'(i));
            bmreq_n = 1'b1; brfsh_n = 1'b1; bm1_n = 1'b1;
            tick();
            chk($sformatf("sw%0d_pre_ras", i), 32'(ras_n), 32'd1);
            chk($sformatf("sw%0d_inc", i), 32'(refcnt), 32'((i + 1) % 256));
            tick();
            $display("refresh %0d: ra7=%0b ref=%0d", i, ra7, refcnt);
        end
        chk("sweep_wrap", 32'(refcnt), 32'd0);

        // One refresh so the reset below has a nonzero counter to clear.
        bmreq_n = 1'b0; brfsh_n = 1'b0;
        tick();
        idle_bus();
        repeat (2) tick();
        chk("pre_rst_ref", 32'(refcnt), 32'd1);

        // Asynchronous reset in the middle of a CAS cycle.
        bmreq_n = 1'b0; brd_n = 1'b0; ba7 = 1'b1;
        repeat (3) tick();
        chk("async_cas_on", 32'(cas1_n), 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1, 1, 1, 0, 0, 8'd0);
        $display("async reset: ras=%0b cas1=%0b cas2=%0b ref=%0d", ras_n, cas1_n, cas2_n, refcnt);
        idle_bus();
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
